// File: rtl/bconv_stream.sv
// bconv_stream: streaming KxK binary convolution engine.
// Pixels arrive one per valid/ready handshake in row-major order. K-1 line
// buffers supply the upper rows of a KxK sliding window. Every pixel that
// completes a full window produces NUM_CH popcount sums (AND or XNOR against
// the loaded kernels) plus their thresholded binary activations. The result
// is held in a single output register that feeds the next layer.
module bconv_stream #(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int K      = 3,
    parameter int NUM_CH = 4,
    parameter int CNT_W  = $clog2(K*K+1),
    parameter int THRESH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mode,
    input  logic                      kern_we,
    input  logic [$clog2(NUM_CH)-1:0] kern_ch,
    input  logic [K*K-1:0]            kern_data,
    input  logic                      pix_valid,
    input  logic                      pix_data,
    output logic                      pix_ready,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NUM_CH*CNT_W-1:0]   out_sum,
    output logic [NUM_CH-1:0]         out_bin,
    output logic                      out_last,
    output logic                      busy,
    output logic                      kern_err
);

    localparam int KK    = K * K;
    localparam int CH_W  = $clog2(NUM_CH);
    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_MIN  = COL_W'(K - 1);
    localparam logic [ROW_W-1:0] ROW_MIN  = ROW_W'(K - 1);

    // Position of the next pixel to be accepted
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;

    // Line buffer j holds the last IMG_W pixels entering it; its MSB is the
    // pixel at the same column, j+1 rows above the incoming pixel.
    logic [IMG_W-1:0] lb_q [K-1];

    // Sliding window, bit [r*K+c]: row r (0 = top), col c (0 = left)
    logic [KK-1:0] win_q, win_d;

    // New right-hand window column, index r = window row
    logic [K-1:0] col_in;

    // Loaded kernels
    logic [KK-1:0] kern_q [NUM_CH];

    // Output register
    logic                    out_valid_q;
    logic [NUM_CH*CNT_W-1:0] out_sum_q, sum_d;
    logic [NUM_CH-1:0]       out_bin_q, bin_d;
    logic                    out_last_q;

    logic busy_q;
    logic kern_err_q;

    logic accept;
    logic win_done;
    logic frame_end;
    logic frame_first;
    logic out_hs;
    logic kern_ok;
    logic kern_rej;

    // Count the set bits of a window-sized vector
    function automatic logic [CNT_W-1:0] popcount(input logic [KK-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < KK; i++) begin
            n = n + {{(CNT_W-1){1'b0}}, v[i]};
        end
        return n;
    endfunction

    // One channel's match count: AND-popcount (mode 0) or XNOR-popcount (mode 1)
    function automatic logic [CNT_W-1:0] chan_sum(input logic [KK-1:0] w,
                                                  input logic [KK-1:0] k,
                                                  input logic          xnor_mode);
        logic [KK-1:0] m;
        m = xnor_mode ? ~(w ^ k) : (w & k);
        return popcount(m);
    endfunction

    // Binary activation: set when the count reaches the threshold
    function automatic logic binarise(input logic [CNT_W-1:0] s);
        return {{(32-CNT_W){1'b0}}, s} >= 32'(THRESH);
    endfunction

    // Handshake and position-derived control
    always_comb begin
        pix_ready   = !rst && (!out_valid_q || out_ready);
        accept      = pix_valid && pix_ready;
        out_hs      = out_valid_q && out_ready;
        win_done    = accept && (row_q >= ROW_MIN) && (col_q >= COL_MIN);
        frame_end   = (row_q == ROW_LAST) && (col_q == COL_LAST);
        frame_first = (row_q == '0) && (col_q == '0);
        kern_ok     = kern_we && !busy_q && ({{(32-CH_W){1'b0}}, kern_ch} < 32'(NUM_CH));
        kern_rej    = kern_we && !kern_ok;
    end

    // Raster counters: column wraps into the next row, last pixel wraps the frame
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Next window: shift left one column, new column from line buffers + pixel
    always_comb begin
        col_in      = '0;
        col_in[K-1] = pix_data;
        for (int r = 0; r < K-1; r++) begin
            col_in[r] = lb_q[K-2-r][IMG_W-1];
        end
        win_d = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K-1; c++) begin
                win_d[r*K+c] = win_q[r*K+c+1];
            end
            win_d[r*K+K-1] = col_in[r];
        end
    end

    // Per-channel sums and activations for the window the current pixel completes
    always_comb begin
        sum_d = '0;
        bin_d = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            sum_d[ch*CNT_W +: CNT_W] = chan_sum(win_d, kern_q[ch], mode);
            bin_d[ch]                = binarise(sum_d[ch*CNT_W +: CNT_W]);
        end
    end

    // Pixel-path state: counters, window and line buffers advance only on accept
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
            win_q <= '0;
            for (int j = 0; j < K-1; j++) begin
                lb_q[j] <= '0;
            end
        end else if (accept) begin
            col_q <= col_d;
            row_q <= row_d;
            win_q <= win_d;
            // Line buffer j is fed by the window column entering row K-1-j
            for (int j = 0; j < K-1; j++) begin
                lb_q[j] <= {lb_q[j][IMG_W-2:0], col_in[K-1-j]};
            end
        end
    end

    // Kernel store; writes only between frames, rejected writes flag an error
    always_ff @(posedge clk) begin
        if (rst) begin
            kern_err_q <= 1'b0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                kern_q[ch] <= '0;
            end
        end else begin
            kern_err_q <= kern_rej;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (kern_ok && (kern_ch == CH_W'(ch))) begin
                    kern_q[ch] <= kern_data;
                end
            end
        end
    end

    // Output register: load on window completion, otherwise drain on handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_bin_q   <= '0;
            out_last_q  <= 1'b0;
        end else if (win_done) begin
            out_valid_q <= 1'b1;
            out_sum_q   <= sum_d;
            out_bin_q   <= bin_d;
            out_last_q  <= frame_end;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // Frame activity: a new frame's first pixel wins over the previous frame's end
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
        end else if (accept && frame_first) begin
            busy_q <= 1'b1;
        end else if (out_hs && out_last_q) begin
            busy_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_bin   = out_bin_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign kern_err  = kern_err_q;

endmodule

// File: tb/tb_bconv_stream.sv
// tb_bconv_stream: randomized scoreboard bench for bconv_stream.
// The driver keeps a picture of the frame as pixels are accepted and, for
// every completed window, pushes the expected sums/activations computed
// straight from the image and the kernels it has loaded. A monitor pops and
// compares on every output handshake and checks hold-while-stalled.
module tb_bconv_stream;

    localparam int W  = 28;
    localparam int H  = 28;
    localparam int K  = 3;
    localparam int NC = 4;
    localparam int CW = 4;
    localparam int TH = 5;
    localparam int NOUT = (W-K+1)*(H-K+1);

    logic              clk = 1'b0;
    logic              rst;
    logic              mode;
    logic              kern_we;
    logic [1:0]        kern_ch;
    logic [K*K-1:0]    kern_data;
    logic              pix_valid;
    logic              pix_data;
    logic              pix_ready;
    logic              out_valid;
    logic              out_ready;
    logic [NC*CW-1:0]  out_sum;
    logic [NC-1:0]     out_bin;
    logic              out_last;
    logic              busy;
    logic              kern_err;

    bconv_stream #(.IMG_W(W), .IMG_H(H), .K(K), .NUM_CH(NC), .CNT_W(CW), .THRESH(TH)) dut (
        .clk(clk), .rst(rst), .mode(mode), .kern_we(kern_we), .kern_ch(kern_ch),
        .kern_data(kern_data), .pix_valid(pix_valid), .pix_data(pix_data),
        .pix_ready(pix_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_bin(out_bin), .out_last(out_last),
        .busy(busy), .kern_err(kern_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NC*CW-1:0] sum;
        logic [NC-1:0]    bin;
        logic             last;
    } exp_t;

    exp_t     q[$];
    int       total = 0;
    int       bad = 0;
    int       pushed = 0;
    int       popped = 0;
    logic [K*K-1:0] km [NC];
    logic     img [H][W];
    int       mr = 0;
    int       mc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s bound expired", name);
    endtask

    // Reference: record the pixel, and if it closes a window compute its result
    task automatic model_accept(input logic p, input logic md);
        exp_t e;
        int   s;
        logic w;
        logic kb;
        img[mr][mc] = p;
        if (mr >= K-1 && mc >= K-1) begin
            e = '0;
            for (int ch = 0; ch < NC; ch++) begin
                s = 0;
                for (int wr = 0; wr < K; wr++) begin
                    for (int wc = 0; wc < K; wc++) begin
                        w  = img[mr-K+1+wr][mc-K+1+wc];
                        kb = km[ch][wr*K+wc];
                        if (md) s += (w == kb) ? 1 : 0;
                        else    s += (w && kb) ? 1 : 0;
                    end
                end
                e.sum[ch*CW +: CW] = s[CW-1:0];
                e.bin[ch]          = (s >= TH);
            end
            e.last = (mr == H-1) && (mc == W-1);
            q.push_back(e);
            pushed++;
        end
        mc++;
        if (mc == W) begin
            mc = 0;
            mr++;
            if (mr == H) mr = 0;
        end
    endtask

    function automatic logic pix_of(input int pat, input int c);
        case (pat)
            0:       return (c % 2 == 0);
            1:       return 1'b1;
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    // Monitor: compare on handshake, check hold and input stall under backpressure
    logic             stalled = 1'b0;
    logic [NC*CW-1:0] h_sum;
    logic [NC-1:0]    h_bin;
    logic             h_last;
    int               frame_outs = 0;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                stalled    = 1'b0;
                frame_outs = 0;
            end else begin
                if (stalled) begin
                    chk("hold_sum", out_sum, h_sum);
                    chk("hold_bin_last", {out_bin, out_last}, {h_bin, h_last});
                end
                if (out_valid && !out_ready) chk("no_accept_stalled", pix_ready, 1'b0);
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_output actual=%0h required=none", out_sum);
                    end else begin
                        e = q.pop_front();
                        popped++;
                        frame_outs++;
                        chk("out_sum", out_sum, e.sum);
                        chk("out_bin", out_bin, e.bin);
                        chk("out_last", out_last, e.last);
                        if (e.last) begin
                            chk("frame_count", frame_outs, NOUT);
                            frame_outs = 0;
                        end
                    end
                end
                stalled = out_valid && !out_ready;
                h_sum   = out_sum;
                h_bin   = out_bin;
                h_last  = out_last;
            end
        end
    end

    // Stream one frame (or the first abort_after pixels); optional rejected kernel write
    task automatic run_frame(input int pat, input int mdsel, input bit bp,
                             input int abort_after, input int err_at,
                             output logic [1:0] e_ch, output logic [K*K-1:0] e_data);
        int   n = 0;
        int   cyc = 0;
        int   errchk = 0;
        bit   err_done = 0;
        logic p;
        logic md;
        e_ch   = '0;
        e_data = '0;
        while (n < abort_after) begin
            @(negedge clk);
            kern_we = 1'b0;
            if (errchk == 1) begin
                chk("kern_err_pulse", kern_err, 1'b1);
                chk("busy_mid_frame", busy, 1'b1);
                errchk = 2;
            end else if (errchk == 2) begin
                chk("kern_err_one_cycle", kern_err, 1'b0);
                errchk = 0;
            end
            out_ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
            pix_valid = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
            md        = (mdsel == 2) ? 1'($urandom_range(0, 1)) : 1'(mdsel);
            p         = pix_of(pat, mc);
            pix_data  = p;
            mode      = md;
            if (!err_done && n == err_at) begin
                err_done  = 1;
                e_ch      = 2'($urandom_range(0, NC-1));
                e_data    = 9'($urandom);
                kern_we   = 1'b1;
                kern_ch   = e_ch;
                kern_data = e_data;
                errchk    = 1;
            end
            #1;
            if (pix_valid && pix_ready) begin
                model_accept(p, md);
                n++;
            end
            cyc++;
            if (cyc > 20000) begin
                fail_now("frame_timeout");
                break;
            end
        end
        @(negedge clk);
        pix_valid = 1'b0;
        kern_we   = 1'b0;
        if (!bp && abort_after == W*H) chk("no_stall_cycles", cyc, n);
    endtask

    task automatic drain(input bit bp);
        int cyc = 0;
        while (q.size() != 0 && cyc < 5000) begin
            @(negedge clk);
            pix_valid = 1'b0;
            out_ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
            #3;
            cyc++;
        end
        if (q.size() != 0) fail_now("drain_timeout");
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        chk("busy_after_frame", busy, 1'b0);
    endtask

    task automatic wr_kern(input int ch, input logic [K*K-1:0] d);
        @(negedge clk);
        kern_we   = 1'b1;
        kern_ch   = 2'(ch);
        kern_data = d;
        km[ch]    = d;
        @(negedge clk);
        kern_we = 1'b0;
        #1;
        chk("kern_err_idle", kern_err, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        pix_valid = 1'b0;
        kern_we   = 1'b0;
        out_ready = 1'b0;
        q.delete();
        mr = 0;
        mc = 0;
        for (int ch = 0; ch < NC; ch++) km[ch] = '0;
        #1;
        chk("pix_ready_in_rst", pix_ready, 1'b0);
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_sum", out_sum, '0);
        chk("rst_bin_last", {out_bin, out_last}, '0);
        chk("rst_busy_err", {busy, kern_err}, 2'b00);
        chk("pix_ready_after_rst", pix_ready, 1'b1);
    endtask

    initial begin
        logic [1:0]     e_ch;
        logic [K*K-1:0] e_data;
        logic [1:0]     d_ch;
        logic [K*K-1:0] d_data;
        rst = 1'b1; mode = 1'b0; kern_we = 1'b0; kern_ch = '0; kern_data = '0;
        pix_valid = 1'b0; pix_data = 1'b0; out_ready = 1'b1;
        for (int ch = 0; ch < NC; ch++) km[ch] = '0;
        do_reset();

        // Checkerboard, AND then XNOR
        wr_kern(0, 9'b101_010_101);
        run_frame(0, 0, 1'b0, W*H, -1, e_ch, e_data);
        drain(1'b0);
        run_frame(0, 1, 1'b0, W*H, -1, e_ch, e_data);
        drain(1'b0);

        // Multi-channel on all-ones image
        wr_kern(1, 9'h1FF);
        wr_kern(2, 9'h000);
        wr_kern(3, 9'b101_010_101);
        run_frame(1, 0, 1'b0, W*H, -1, e_ch, e_data);
        drain(1'b0);

        // Backpressure, random image and mode, rejected kernel write mid-frame
        run_frame(2, 2, 1'b1, W*H, 300, e_ch, e_data);
        drain(1'b1);
        wr_kern(int'(e_ch), e_data);
        run_frame(2, 2, 1'b1, W*H, -1, d_ch, d_data);
        drain(1'b1);

        // Abort after 100 pixels, reset, reload kernels, full fresh frame
        run_frame(2, 2, 1'b1, 100, -1, d_ch, d_data);
        do_reset();
        wr_kern(0, 9'($urandom));
        wr_kern(1, 9'($urandom));
        wr_kern(2, 9'($urandom));
        wr_kern(3, 9'($urandom));
        run_frame(2, 2, 1'b1, W*H, -1, d_ch, d_data);
        drain(1'b1);

        repeat (2) @(negedge clk);
        chk("all_outputs_seen", popped, pushed);
        chk("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bconv_stream.md
Name: bconv_stream

Overview:
- Streaming, parametrised binary 3x3-class convolution engine for the BNN datapath.
- Accepts a binarised image one pixel per handshake, in row-major order.
- Keeps K-1 line buffers plus a KxK sliding window.
- For every valid window position, emits NUM_CH popcount results, one per loaded kernel, plus thresholded binary activations.
- Replaces the fixed 28x28 / single-kernel / 4-bit combinational convolution with a valid/ready pipeline feeding the next BNN layer.

Parameters:
- IMG_W, 28, image width in pixels (>= K).
- IMG_H, 28, image height in pixels (>= K).
- K, 3, square kernel size.
- NUM_CH, 4, number of kernels / output channels.
- CNT_W, $clog2(K*K+1), popcount width per channel (4 for K=3).
- THRESH, 5, binarisation threshold; out_bin[ch] = (sum[ch] >= THRESH).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- mode  in  1  0 = AND-popcount, 1 = XNOR-popcount; sampled per accepted pixel.
- kern_we  in  1  kernel write strobe.
- kern_ch  in  $clog2(NUM_CH)  kernel index to write.
- kern_data  in  K*K  kernel bits; bit [r*K+c] = row r (0 = top), col c (0 = left).
- pix_valid  in  1  input pixel valid.
- pix_data  in  1  binary pixel.
- pix_ready  out  1  input ready.
- out_valid  out  1  output valid.
- out_ready  in  1  downstream ready.
- out_sum  out  NUM_CH*CNT_W  channel ch in bits [ch*CNT_W +: CNT_W].
- out_bin  out  NUM_CH  thresholded activations.
- out_last  out  1  high with the final window of a frame.
- busy  out  1  frame in progress.
- kern_err  out  1  one-cycle pulse when kern_we is rejected.

Behaviour:
- Reset values:
  - pix_ready=0 during rst, 1 from the first cycle after.
  - out_valid=0, out_sum=0, out_bin=0, out_last=0, busy=0, kern_err=0.
  - Column/row counters = 0.
  - Line buffers and kernel registers cleared to 0.
- Handshake:
  - A pixel is accepted when pix_valid && pix_ready.
  - pix_ready = !out_valid || out_ready (single output register, no bubble under continuous flow).
  - out_* stay stable while out_valid && !out_ready.
- Window:
  - Each accepted pixel shifts into the window's bottom row at the right edge.
  - The window's upper rows come from the line buffers at the same column.
  - Each line buffer is IMG_W deep and advances only on acceptance.
- Counters:
  - col increments 0..IMG_W-1 per accept, then wraps to 0 and row increments.
  - After the pixel at (IMG_H-1, IMG_W-1), both counters return to 0.
- Output generation:
  - An accepted pixel at (row, col) with row >= K-1 and col >= K-1 completes a window whose top-left is (row-K+1, col-K+1).
  - For that pixel, out_valid rises the next cycle (latency 1).
  - Accepts that do not complete a window do not produce output and do not clear a pending output.
- Arithmetic:
  - sum[ch] = popcount over K*K of (w & k) in mode 0, or ~(w ^ k) in mode 1.
  - The result is unsigned, max K*K, no saturation needed.
- Per-frame counts:
  - Output count per frame = (IMG_W-K+1)*(IMG_H-K+1).
  - out_last is set with the output from pixel (IMG_H-1, IMG_W-1).
- Frame row boundary: window columns from the previous row never produce output, because of the col >= K-1 gate.
- busy:
  - Set on the first accepted pixel of a frame.
  - Cleared the cycle after the out_last output handshakes.
- Kernel writes:
  - kern_we with busy=0 writes kern_data into kernel[kern_ch] at the clock edge; used from the next accepted pixel.
  - kern_we with busy=1 is ignored and kern_err pulses for 1 cycle.
  - kern_ch >= NUM_CH is ignored and kern_err pulses.
- Reset mid-frame:
  - All state returns to reset values, including the kernels.
  - The next accepted pixel is treated as (0,0).
- Simultaneous events:
  - If the output handshakes and a new completing pixel is accepted in the same cycle, out_valid stays 1 with new data.
  - rst overrides all other inputs.

Test Plan:
- Checkerboard, mode 0: 28x28, every row alternating starting with pixel 1 at col 0; kernel[0] = rows 101/010/101; pixels streamed with out_ready=1 -> 676 outputs, no stalls; ch0 sum = 4 for even top-left col, 1 for odd; out_last only on output 676.
- Same image, mode 1 -> ch0 sum = 6 (even col), 3 (odd col); out_bin[0] = 1, 0 respectively with THRESH=5.
- Multi-channel: kernel[1]=all ones, kernel[2]=all zeros, kernel[3]=kernel[0], mode 0 on an all-ones image -> sums 5, 9, 0, 5 for every window; out_bin = 4'b1011.
- Backpressure: out_ready toggled pseudo-randomly, pix_valid random ->
  - out_* held stable while stalled;
  - no pixel accepted when out_valid && !out_ready;
  - output sequence identical to the unstalled run.
- Kernel write while busy: kern_we mid-frame -> kern_err=1 for 1 cycle; frame results unchanged; the same write after busy falls takes effect on the next frame.
- Reset mid-frame: rst for 1 cycle after 100 pixels, then a full fresh frame with kernels reloaded -> exactly 676 correct outputs; no output from the aborted partial frame.
